// File: rtl/armleocpu_ptw_pkg.sv
// Shared Sv32 definitions for the page-table walker: PTE flag positions,
// field accessors, bus response codes and walker state encoding.
package armleocpu_ptw_pkg;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

  localparam int PA_W  = 34;
  localparam int PPN_W = 22;
  localparam int VPN_W = 20;

  localparam logic [1:0] AVL_OKAY = 2'b00;

  typedef enum logic [1:0] {
    PTW_IDLE  = 2'd0,
    PTW_ISSUE = 2'd1,
    PTW_WAIT  = 2'd2
  } ptw_state_t;

  function automatic logic [21:0] pte_ppn(input logic [31:0] pte);
    return pte[31:10];
  endfunction

  function automatic logic [11:0] pte_ppn1(input logic [31:0] pte);
    return pte[31:20];
  endfunction

  function automatic logic [9:0] pte_ppn0(input logic [31:0] pte);
    return pte[19:10];
  endfunction

endpackage

// File: rtl/armleocpu_ptw_pte_decode.sv
// Combinational classification of one fetched PTE: leaf, descend, or fault.
// Bus errors win over any PTE-content fault.
module armleocpu_ptw_pte_decode
  import armleocpu_ptw_pkg::*;
(
  input  logic [31:0] pte,
  input  logic        level,
  input  logic [1:0]  response,
  output logic        leaf,
  output logic        next_level,
  output logic        pagefault,
  output logic        accessfault
);

  logic is_leaf;
  logic invalid;
  logic misaligned;
  logic unused_pte_bits;

  assign unused_pte_bits = ^{pte[31:20], pte[9:4]};

  always_comb begin
    accessfault = (response != AVL_OKAY);
    is_leaf     = pte[PTE_R] | pte[PTE_X];
    invalid     = !pte[PTE_V] | (!pte[PTE_R] & pte[PTE_W]);
    // a level-1 leaf maps a 4 MiB superpage, so its low PPN field must be zero
    misaligned  = level & is_leaf & (pte_ppn0(pte) != 10'd0);
    pagefault   = !accessfault & (invalid | misaligned | (!is_leaf & !level));
    leaf        = !accessfault & !invalid & !misaligned & is_leaf;
    next_level  = !accessfault & !invalid & !is_leaf & level;
  end

endmodule

// File: rtl/armleocpu_ptw.sv
// Sv32 page-table walker: fetches up to two PTEs over a single-outstanding
// read port and returns the PPN plus the PTE access tag to the cache.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   PTW_IDLE  | waiting for resolve_request (not accepted in the done cycle)
//   PTW_ISSUE | avl_read held with stable address until waitrequest drops
//   PTW_WAIT  | read accepted, waiting for readdatavalid, decode on arrival
module armleocpu_ptw
  import armleocpu_ptw_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 resolve_request,
  input  logic [VPN_W-1:0]     resolve_virtual_address,
  input  logic [PPN_W-1:0]     satp_ppn,
  output logic                 resolve_ack,
  output logic                 resolve_done,
  output logic                 resolve_pagefault,
  output logic                 resolve_accessfault,
  output logic [PPN_W-1:0]     resolve_physical_address,
  output logic [7:0]           resolve_metadata,
  output logic [PA_W-1:0]      avl_address,
  output logic                 avl_read,
  input  logic                 avl_waitrequest,
  input  logic [31:0]          avl_readdata,
  input  logic                 avl_readdatavalid,
  input  logic [1:0]           avl_response
);

  ptw_state_t state;
  logic       level;
  logic [9:0] vpn0;

  logic dec_leaf;
  logic dec_next_level;
  logic dec_pagefault;
  logic dec_accessfault;

  armleocpu_ptw_pte_decode u_pte_decode (
    .pte         (avl_readdata),
    .level       (level),
    .response    (avl_response),
    .leaf        (dec_leaf),
    .next_level  (dec_next_level),
    .pagefault   (dec_pagefault),
    .accessfault (dec_accessfault)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= PTW_IDLE;
      level                    <= 1'b0;
      vpn0                     <= '0;
      resolve_ack              <= 1'b0;
      resolve_done             <= 1'b0;
      resolve_pagefault        <= 1'b0;
      resolve_accessfault      <= 1'b0;
      resolve_physical_address <= '0;
      resolve_metadata         <= '0;
      avl_address              <= '0;
      avl_read                 <= 1'b0;
    end else begin
      resolve_ack              <= 1'b0;
      resolve_done             <= 1'b0;
      resolve_pagefault        <= 1'b0;
      resolve_accessfault      <= 1'b0;
      resolve_physical_address <= '0;
      resolve_metadata         <= '0;

      case (state)
        PTW_IDLE: begin
          // resolve_done high means this is the done cycle of the last walk
          if (resolve_request && !resolve_done) begin
            resolve_ack <= 1'b1;
            level       <= 1'b1;
            vpn0        <= resolve_virtual_address[9:0];
            avl_address <= {satp_ppn, resolve_virtual_address[19:10], 2'b00};
            avl_read    <= 1'b1;
            state       <= PTW_ISSUE;
          end
        end

        PTW_ISSUE: begin
          if (!avl_waitrequest) begin
            avl_read <= 1'b0;
            state    <= PTW_WAIT;
          end
        end

        PTW_WAIT: begin
          if (avl_readdatavalid) begin
            if (dec_next_level) begin
              level       <= 1'b0;
              avl_address <= {pte_ppn(avl_readdata), vpn0, 2'b00};
              avl_read    <= 1'b1;
              state       <= PTW_ISSUE;
            end else begin
              resolve_done        <= 1'b1;
              resolve_pagefault   <= dec_pagefault;
              resolve_accessfault <= dec_accessfault;
              if (dec_leaf) begin
                resolve_metadata         <= avl_readdata[7:0];
                resolve_physical_address <= level ? {pte_ppn1(avl_readdata), vpn0}
                                                  : pte_ppn(avl_readdata);
              end
              state <= PTW_IDLE;
            end
          end
        end

        default: state <= PTW_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_ptw.sv
// Directed bench for armleocpu_ptw: table of walks against a small memory
// responder, plus hand sequences for request timing and mid-walk reset.
module tb_armleocpu_ptw;

  logic        clk = 1'b0;
  logic        rst;
  logic        resolve_request;
  logic [19:0] resolve_virtual_address;
  logic [21:0] satp_ppn;
  logic        resolve_ack;
  logic        resolve_done;
  logic        resolve_pagefault;
  logic        resolve_accessfault;
  logic [21:0] resolve_physical_address;
  logic [7:0]  resolve_metadata;
  logic [33:0] avl_address;
  logic        avl_read;
  logic        avl_waitrequest;
  logic [31:0] avl_readdata;
  logic        avl_readdatavalid;
  logic [1:0]  avl_response;

  int errors = 0;
  int checks = 0;

  armleocpu_ptw dut (
    .clk                      (clk),
    .rst                      (rst),
    .resolve_request          (resolve_request),
    .resolve_virtual_address  (resolve_virtual_address),
    .satp_ppn                 (satp_ppn),
    .resolve_ack              (resolve_ack),
    .resolve_done             (resolve_done),
    .resolve_pagefault        (resolve_pagefault),
    .resolve_accessfault      (resolve_accessfault),
    .resolve_physical_address (resolve_physical_address),
    .resolve_metadata         (resolve_metadata),
    .avl_address              (avl_address),
    .avl_read                 (avl_read),
    .avl_waitrequest          (avl_waitrequest),
    .avl_readdata             (avl_readdata),
    .avl_readdatavalid        (avl_readdatavalid),
    .avl_response             (avl_response)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [21:0] satp;
    logic [19:0] vpn;
    logic [31:0] pte1;
    logic [1:0]  resp1;
    logic [31:0] pte0;
    int          stall;
    int          dly;
    bit          hold;
    int          reads;
    logic [33:0] addr1;
    logic [33:0] addr0;
    int          cyc;
    bit          pf;
    bit          af;
    logic [21:0] phys;
    logic [7:0]  meta;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [21:0] satp, input logic [19:0] vpn,
                              input logic [31:0] pte1, input logic [1:0] resp1, input logic [31:0] pte0,
                              input int stall, input int dly, input bit hold, input int reads,
                              input logic [33:0] addr1, input logic [33:0] addr0, input int cyc,
                              input bit pf, input bit af, input logic [21:0] phys, input logic [7:0] meta);
    vec_t v;
    v.name = name; v.satp = satp; v.vpn = vpn; v.pte1 = pte1; v.resp1 = resp1; v.pte0 = pte0;
    v.stall = stall; v.dly = dly; v.hold = hold; v.reads = reads; v.addr1 = addr1; v.addr0 = addr0;
    v.cyc = cyc; v.pf = pf; v.af = af; v.phys = phys; v.meta = meta;
    return v;
  endfunction

  task automatic chk_quiet(input string nm);
    chk(nm, 64'({resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault, avl_read,
                 avl_address, resolve_physical_address, resolve_metadata}), 64'd0);
  endtask

  // Drives one walk; cycle 0 is the cycle the request is first presented.
  task automatic run_vec(input vec_t v);
    int cyc = 0, nreads = 0, nacks = 0, stall_left = v.stall, cd = 0, pidx = 0;
    bit pending = 0, seen_done = 0;
    logic [33:0] exp_addr;
    resolve_virtual_address = v.vpn;
    satp_ppn = v.satp;
    resolve_request = 1'b1;
    while (!seen_done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      avl_readdatavalid = 1'b0;
      avl_readdata = '0;
      avl_response = 2'b00;
      if (pending) begin
        if (cd == 0) begin
          avl_readdatavalid = 1'b1;
          avl_readdata = (pidx == 0) ? v.pte1 : v.pte0;
          avl_response = (pidx == 0) ? v.resp1 : 2'b00;
          pending = 0;
        end else cd--;
      end
      if (resolve_ack) begin
        nacks++;
        if (!v.hold) resolve_request = 1'b0;
      end
      if (resolve_done) begin
        seen_done = 1;
        chk({v.name, "/latency"}, 64'(cyc), 64'(v.cyc));
        chk({v.name, "/pagefault"}, 64'(resolve_pagefault), 64'(v.pf));
        chk({v.name, "/accessfault"}, 64'(resolve_accessfault), 64'(v.af));
        chk({v.name, "/physical"}, 64'(resolve_physical_address), 64'(v.phys));
        chk({v.name, "/metadata"}, 64'(resolve_metadata), 64'(v.meta));
      end
      if (avl_read) begin
        exp_addr = (nreads == 0) ? v.addr1 : v.addr0;
        chk({v.name, "/avl_address"}, 64'(avl_address), 64'(exp_addr));
        if (stall_left > 0) begin
          avl_waitrequest = 1'b1;
          stall_left--;
        end else begin
          avl_waitrequest = 1'b0;
          pending = 1; cd = v.dly; pidx = nreads; nreads++;
        end
      end else avl_waitrequest = 1'b0;
    end
    chk({v.name, "/done_seen"}, 64'(seen_done), 64'd1);
    chk({v.name, "/reads"}, 64'(nreads), 64'(v.reads));
    chk({v.name, "/acks"}, 64'(nacks), 64'd1);
    if (!v.hold) begin
      @(negedge clk);
      avl_readdatavalid = 1'b0;
      chk({v.name, "/done_pulse_idle"}, 64'({resolve_done, resolve_ack, avl_read}), 64'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs.push_back(mk("two_level",  22'h00001, 20'h00402, 32'h00000801, 2'b00, 32'h0000CCCF, 0, 0, 0, 2, 34'h1004, 34'h2008, 5, 0, 0, 22'h00033, 8'hCF));
    vecs.push_back(mk("superpage",  22'h00001, 20'h00402, 32'h001000CF, 2'b00, 32'h0,        0, 0, 0, 1, 34'h1004, 34'h0,    3, 0, 0, 22'h00402, 8'hCF));
    vecs.push_back(mk("x_only",     22'h00001, 20'h00402, 32'h00000009, 2'b00, 32'h0,        0, 0, 0, 1, 34'h1004, 34'h0,    3, 0, 0, 22'h00002, 8'h09));
    vecs.push_back(mk("v_zero",     22'h00001, 20'h00402, 32'h00000000, 2'b00, 32'h0,        0, 0, 0, 1, 34'h1004, 34'h0,    3, 1, 0, 22'h0,     8'h00));
    vecs.push_back(mk("w_no_r",     22'h00001, 20'h00402, 32'h00000005, 2'b00, 32'h0,        0, 0, 0, 1, 34'h1004, 34'h0,    3, 1, 0, 22'h0,     8'h00));
    vecs.push_back(mk("misaligned", 22'h00001, 20'h00402, 32'h00000CCF, 2'b00, 32'h0,        0, 0, 0, 1, 34'h1004, 34'h0,    3, 1, 0, 22'h0,     8'h00));
    vecs.push_back(mk("nonleaf_l0", 22'h00001, 20'h00402, 32'h00000801, 2'b00, 32'h00000801, 0, 0, 0, 2, 34'h1004, 34'h2008, 5, 1, 0, 22'h0,     8'h00));
    vecs.push_back(mk("acc_leaf",   22'h00001, 20'h00402, 32'h001000CF, 2'b11, 32'h0,        0, 0, 0, 1, 34'h1004, 34'h0,    3, 0, 1, 22'h0,     8'h00));
    vecs.push_back(mk("acc_nonleaf",22'h00001, 20'h00402, 32'h00000801, 2'b10, 32'h0,        0, 0, 0, 1, 34'h1004, 34'h0,    3, 0, 1, 22'h0,     8'h00));
    vecs.push_back(mk("stall4",     22'h00001, 20'h00402, 32'h001000CF, 2'b00, 32'h0,        4, 0, 0, 1, 34'h1004, 34'h0,    7, 0, 0, 22'h00402, 8'hCF));
    vecs.push_back(mk("delay3",     22'h00001, 20'h00402, 32'h00000801, 2'b00, 32'h0000CCCF, 0, 3, 0, 2, 34'h1004, 34'h2008, 11, 0, 0, 22'h00033, 8'hCF));
    vecs.push_back(mk("other_root", 22'h2ABCD, 20'hFFC01, 32'h048D1401, 2'b00, 32'hFFFFFC0B, 0, 0, 0, 2, 34'h2ABCDFFC, 34'h12345004, 5, 0, 0, 22'h3FFFFF, 8'h0B));

    rst = 1'b1;
    resolve_request = 1'b0;
    resolve_virtual_address = '0;
    satp_ppn = '0;
    avl_waitrequest = 1'b0;
    avl_readdata = '0;
    avl_readdatavalid = 1'b0;
    avl_response = 2'b00;
    repeat (3) @(negedge clk);
    chk_quiet("reset_outputs");
    rst = 1'b0;

    // stray read data while idle must not produce a result
    @(negedge clk);
    avl_readdatavalid = 1'b1;
    avl_readdata = 32'h001000CF;
    @(negedge clk);
    avl_readdatavalid = 1'b0;
    chk_quiet("stray_valid_idle");

    foreach (vecs[i]) run_vec(vecs[i]);

    // request held through the whole walk: no second ack, none in done cycle
    run_vec(mk("held_req", 22'h00001, 20'h00402, 32'h001000CF, 2'b00, 32'h0, 0, 0, 1, 1, 34'h1004, 34'h0, 3, 0, 0, 22'h00402, 8'hCF));
    @(negedge clk);
    chk("held_req/no_ack_done_cycle", 64'(resolve_ack), 64'd0);
    @(negedge clk);
    chk("held_req/ack_after_done", 64'(resolve_ack), 64'd1);
    chk("held_req/reissue_addr", 64'({avl_read, avl_address}), 64'({1'b1, 34'h1004}));
    resolve_request = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("reset_in_issue");
    rst = 1'b0;

    // reset while waiting on the level-0 read
    @(negedge clk);
    resolve_virtual_address = 20'h00402;
    satp_ppn = 22'h00001;
    resolve_request = 1'b1;
    @(negedge clk);
    chk("rst_seq/ack", 64'(resolve_ack), 64'd1);
    resolve_request = 1'b0;
    avl_waitrequest = 1'b0;
    @(negedge clk);
    avl_readdatavalid = 1'b1;
    avl_readdata = 32'h00000801;
    @(negedge clk);
    avl_readdatavalid = 1'b0;
    chk("rst_seq/l0_read", 64'({avl_read, avl_address}), 64'({1'b1, 34'h2008}));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("rst_seq/outputs_cleared");
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("rst_seq/stays_idle");
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
